// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
//
// Contents:
//   riscv_inst32_t : raw 32-bit RISC-V instruction word
//   fetch_entry_t  : {pc, inst} pair held in the instruction queue
//   RISCV_NOP      : canonical NOP encoding (addi x0, x0, 0)
//   PC_STEP        : sequential fetch increment in bytes
package fetch_unit_pkg;

    typedef logic [31:0] riscv_inst32_t;

    typedef struct packed {
        logic [31:0]   pc;
        riscv_inst32_t inst;
    } fetch_entry_t;

    localparam logic [31:0] RISCV_NOP = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO used twice by the fetch unit, once as
// the instruction queue and once as the per-request PC FIFO.
//
// Parameters:
//   DEPTH : number of entries (>= 2)
//   T     : entry type, fetch_entry_t by default
//
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears storage too)
//   push     : write din at the tail; ignored when full unless popping
//   pop      : drop the head entry; ignored when empty
//   flush    : empty the FIFO; wins over push and pop in the same cycle
//   din      : entry to write
//   dout     : head entry, read combinationally from registered storage
//   empty    : no entries held
//   full     : DEPTH entries held
//   count    : number of entries held
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  T                           din,
    output T                           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Explicit wrap keeps the pointers correct for non power-of-2 depths.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the single-cycle datapath.
//
// Fetches sequential word-aligned PCs over a req/gnt/rvalid memory port,
// queues returned instructions in order and hands {inst, pc} to the datapath.
// A redirect flushes the queue, marks every in-flight response for discard
// and restarts fetch at the target.
//
// Optional build macro: FETCH_PERF_CNT_EN adds the perf_fetch_stall and
// perf_flush_drop saturating counters and their ports.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   redirect_valid  : flush and restart at redirect_pc (bits [1:0] ignored)
//   redirect_pc     : redirect target
//   imem_req        : request valid, address in imem_addr
//   imem_addr       : word-aligned request address
//   imem_gnt        : request accepted this cycle
//   imem_rvalid     : in-order response valid, data in imem_rdata
//   imem_rdata      : response instruction
//   inst_valid      : queue head valid
//   inst_ready      : datapath consumes the head
//   inst, inst_pc   : head instruction and its PC
//   perf_fetch_stall: (macro only) cycles with inst_ready && !inst_valid
//   perf_flush_drop : (macro only) queue entries flushed + responses dropped
//
// Handshakes: imem_req/imem_gnt and inst_valid/inst_ready both transfer on the
// cycle where both are high. Once imem_req rises it stays high with a stable
// imem_addr until granted; only a redirect may withdraw it.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned    AW              = 32,
    parameter int unsigned    DW              = 32,
    parameter int unsigned    DEPTH           = 4,
    parameter int unsigned    MAX_OUTSTANDING = 2,
    parameter logic [AW-1:0]  RESET_PC        = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst,
    output logic [AW-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetch_stall,
    output logic [31:0]   perf_flush_drop
`endif
);

    localparam int unsigned QCW = $clog2(DEPTH + 1);
    localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);

    logic [AW-1:0]  fetch_pc_q, fetch_pc_d;
    logic [OCW-1:0] drop_q, drop_d;
    logic           req_fire;
    logic           credit_ok;

    fetch_entry_t   q_din, q_dout;
    logic           q_push, q_pop, q_empty, q_full;
    logic [QCW-1:0] q_count;

    logic [AW-1:0]  pcq_dout;
    logic           pcq_push, pcq_pop, pcq_empty, pcq_full;
    logic [OCW-1:0] outstanding;

    // Instruction queue.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_inst_q (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect_valid),
        .din   (q_din),
        .dout  (q_dout),
        .empty (q_empty),
        .full  (q_full),
        .count (q_count)
    );

    // PC of every granted request, popped by its response. It is never
    // flushed: dropped responses still retire their PC entry, so its
    // occupancy is exactly the outstanding request count.
    fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (logic [AW-1:0])
    ) u_pc_q (
        .clk   (clk),
        .rst   (rst),
        .push  (pcq_push),
        .pop   (pcq_pop),
        .flush (1'b0),
        .din   (fetch_pc_q),
        .dout  (pcq_dout),
        .empty (pcq_empty),
        .full  (pcq_full),
        .count (outstanding)
    );

    // Queued plus in-flight instructions must fit the queue, so no response
    // can ever find it full. Neither term can grow without a grant, which
    // keeps a raised request stable until it is accepted.
    assign credit_ok = ((32'(q_count) + 32'(outstanding)) < 32'(DEPTH)) &&
                       !q_full && !pcq_full;
    assign imem_req  = !rst && !redirect_valid && credit_ok;
    assign imem_addr = fetch_pc_q;
    assign req_fire  = imem_req && imem_gnt;

    assign pcq_push  = req_fire;
    assign pcq_pop   = imem_rvalid && !pcq_empty;

    assign q_din     = '{pc: 32'(pcq_dout), inst: riscv_inst32_t'(imem_rdata)};
    assign q_push    = imem_rvalid && (drop_q == '0) && !redirect_valid;
    assign q_pop     = inst_ready && !q_empty && !redirect_valid;

    assign inst_valid = !q_empty;
    assign inst       = DW'(q_dout.inst);
    assign inst_pc    = AW'(q_dout.pc);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~AW'(3);
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + AW'(PC_STEP);
        end
    end

    // On redirect every request still in flight after this cycle belongs to
    // the old stream; the response (if any) arriving now is dropped directly.
    always_comb begin
        drop_d = drop_q;
        if (redirect_valid) begin
            drop_d = OCW'(32'(outstanding) + 32'(req_fire) - 32'(imem_rvalid));
        end else if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_inc;
    logic [32:0] flush_sum;

    always_comb begin
        flush_inc = '0;
        if (redirect_valid) begin
            flush_inc = 32'(q_count) + 32'(imem_rvalid);
        end else if (imem_rvalid && (drop_q != '0)) begin
            flush_inc = 32'd1;
        end
        flush_sum = {1'b0, flush_cnt_q} + {1'b0, flush_inc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (inst_ready && q_empty && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            flush_cnt_q <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end

    assign perf_fetch_stall = stall_cnt_q;
    assign perf_flush_drop  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. Memory model, scoreboard and directed/random
// scenarios; build with FETCH_PERF_CNT_EN to also cover the perf counters.
module tb_fetch_unit;

    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetch_stall;
    logic [31:0]   perf_flush_drop;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_stall(perf_fetch_stall), .perf_flush_drop(perf_flush_drop)
`endif
    );

    // Memory model: each granted request becomes a response due at a later cycle,
    // tagged with the fetch stream (epoch) it was issued in.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_ent_t;

    mem_ent_t    mem_q[$];
    logic [31:0] exp_q[$];      // PCs the datapath must see next, in order

    int checks = 0;
    int errors = 0;
    int cyc;
    int epoch;
    int occ;                    // instructions held for the datapath
    int outs;                   // granted requests not yet answered
    logic [31:0] exp_fetch;     // address of the next request
    logic        hold_req;
    logic [31:0] hold_addr;
    int gnt_mode;               // 0 always, 1 random, 2 never
    int gnt_pct;
    int lat_min, lat_max;
    int m_stall, m_drop;

    logic        obs_req, obs_valid, obs_rvalid, obs_pop;
    logic [31:0] obs_addr, obs_pop_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    task automatic clear_model();
        mem_q.delete();
        exp_q.delete();
        cyc = 0; epoch = 0; occ = 0; outs = 0;
        exp_fetch = RESET_PC;
        hold_req = 1'b0; hold_addr = '0;
        m_stall = 0; m_drop = 0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== RESET_PC ||
            inst !== '0 || inst_pc !== '0) begin
            errors++;
            $display("FAIL %s: req=%b valid=%b addr=%h inst=%h pc=%h, required 0 0 %h 0 0",
                     tag, imem_req, inst_valid, imem_addr, inst, inst_pc, RESET_PC);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetch_stall !== 32'd0 || perf_flush_drop !== 32'd0) begin
            errors++;
            $display("FAIL %s_perf: stall=%0d drop=%0d, required 0 0", tag, perf_fetch_stall, perf_flush_drop);
        end
`endif
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset_values");
        rst = 1'b0;
        clear_model();
    endtask

    // One clock cycle: drive memory, check outputs against the model, update
    // the model with what transfers at the coming edge, advance to next negedge.
    task automatic step();
        mem_ent_t    e;
        logic        exp_req;
        logic [31:0] e_pc;
        case (gnt_mode)
            0:       imem_gnt = 1'b1;
            2:       imem_gnt = 1'b0;
            default: imem_gnt = ($urandom_range(0, 99) < gnt_pct);
        endcase
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
        end
        #1;
        obs_req = imem_req; obs_addr = imem_addr; obs_valid = inst_valid;
        obs_rvalid = imem_rvalid; obs_pop = 1'b0; obs_pop_pc = '0;

        exp_req = (occ + outs < DEPTH) && (outs < MAX_OUT) && !redirect_valid;
        checks++;
        if (imem_req !== exp_req) begin
            errors++;
            $display("FAIL credit_req cyc %0d: got %b required %b (occ %0d outs %0d)", cyc, imem_req, exp_req, occ, outs);
        end
        checks++;
        if (inst_valid !== (occ > 0)) begin
            errors++;
            $display("FAIL inst_valid cyc %0d: got %b required %b", cyc, inst_valid, occ > 0);
        end
        if (hold_req && !redirect_valid) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== hold_addr) begin
                errors++;
                $display("FAIL req_stable cyc %0d: req=%b addr=%h required 1 %h", cyc, imem_req, imem_addr, hold_addr);
            end
        end
        if (imem_req === 1'b1) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
                errors++;
                $display("FAIL fetch_addr cyc %0d: got %h required %h", cyc, imem_addr, exp_fetch);
            end
        end
        if (inst_valid === 1'b1 && inst_ready && !redirect_valid) begin
            obs_pop = 1'b1;
            obs_pop_pc = inst_pc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty cyc %0d: got pc %h, no instruction expected", cyc, inst_pc);
            end else begin
                e_pc = exp_q.pop_front();
                if (inst_pc !== e_pc || inst !== mem_word(e_pc)) begin
                    errors++;
                    $display("FAIL sb_inst cyc %0d: got pc %h inst %h required pc %h inst %h",
                             cyc, inst_pc, inst, e_pc, mem_word(e_pc));
                end
            end
            if (occ > 0) occ--;
        end
        if (inst_ready && inst_valid !== 1'b1) m_stall++;

        if (imem_rvalid) begin
            e = mem_q.pop_front();
            outs--;
            if (!redirect_valid && e.epoch == epoch) occ++;
            else m_drop++;
        end
        if (imem_req === 1'b1 && imem_gnt) begin
            mem_q.push_back('{addr: imem_addr, epoch: epoch,
                              due: cyc + int'($urandom_range(lat_min, lat_max))});
            outs++;
            exp_q.push_back(imem_addr);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redirect_valid) begin
            m_drop += occ;
            occ = 0;
            epoch++;
            exp_q.delete();
            exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        end
        hold_req  = (imem_req === 1'b1) && !imem_gnt;
        hold_addr = imem_addr;
        @(negedge clk);
        cyc++;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        step();
        redirect_valid = 1'b0;
    endtask

    // Runs until the next delivered instruction and checks its PC.
    task automatic expect_first_pop(input string tag, input logic [31:0] pc);
        int n = 0;
        inst_ready = 1'b1;
        obs_pop = 1'b0;
        while (!obs_pop && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (!obs_pop || obs_pop_pc !== pc) begin
            errors++;
            $display("FAIL %s: first pc %h (seen %b) required %h", tag, obs_pop_pc, obs_pop, pc);
        end
    endtask

    task automatic test_reset();
        gnt_mode = 0; lat_min = 1; lat_max = 1;
        apply_reset();
    endtask

    task automatic test_stream();
        apply_reset();
        gnt_mode = 0; lat_min = 1; lat_max = 1;
        inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (i < 2) begin
                if (obs_pop) begin
                    errors++;
                    $display("FAIL stream_latency cycle %0d: got early pop pc %h", i, obs_pop_pc);
                end
            end else if (!obs_pop || obs_pop_pc !== 32'(4 * (i - 2))) begin
                errors++;
                $display("FAIL stream_rate cycle %0d: pop=%b pc=%h required 1 %h", i, obs_pop, obs_pop_pc, 32'(4 * (i - 2)));
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        gnt_mode = 0; lat_min = 1; lat_max = 1;
        inst_ready = 1'b0;
        repeat (10) step();
        checks++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_credit: req=%b valid=%b required 0 1", obs_req, obs_valid);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (!obs_pop || obs_pop_pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stall_resume %0d: pop=%b pc=%h required 1 %h", i, obs_pop, obs_pop_pc, 32'(4 * i));
            end
        end
        repeat (6) step();
    endtask

    task automatic test_gnt_wait();
        apply_reset();
        lat_min = 1; lat_max = 1;
        inst_ready = 1'b1;
        gnt_mode = 0;
        step();
        step();
        gnt_mode = 2;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== 32'h8) begin
                errors++;
                $display("FAIL gnt_wait_hold %0d: req=%b addr=%h required 1 00000008", i, obs_req, obs_addr);
            end
        end
        gnt_mode = 0;
        step();
        step();
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'hC) begin
            errors++;
            $display("FAIL gnt_wait_advance: req=%b addr=%h required 1 0000000c", obs_req, obs_addr);
        end
        repeat (6) step();
    endtask

    task automatic test_redirect();
        int n = 0;
        apply_reset();
        gnt_mode = 0; lat_min = 2; lat_max = 2;
        inst_ready = 1'b1;
        step();
        while (outs != 2 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (outs != 2) begin
            errors++;
            $display("FAIL redirect_setup: outstanding %0d required 2", outs);
        end
        redirect_to(32'h100);
        step();
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_flush: inst_valid %b required 0", obs_valid);
        end
        expect_first_pop("redirect_target", 32'h100);
        repeat (8) step();
    endtask

    task automatic test_redirect_rvalid();
        int n = 0;
        apply_reset();
        gnt_mode = 0; lat_min = 1; lat_max = 1;
        inst_ready = 1'b1;
        step();
        while (!(mem_q.size() > 0 && mem_q[0].due <= cyc) && n < 20) begin
            step();
            n++;
        end
        redirect_to(32'h203);
        checks++;
        if (obs_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_rvalid_setup: rvalid %b required 1", obs_rvalid);
        end
        expect_first_pop("redirect_align", 32'h200);
        repeat (8) step();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        gnt_mode = 0; lat_min = 1; lat_max = 2;
        inst_ready = 1'b1;
        repeat (5) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect_pc = 32'h404;
        step();
        redirect_valid = 1'b0;
        expect_first_pop("back_to_back", 32'h404);
        repeat (8) step();
    endtask

    task automatic test_random();
        apply_reset();
        gnt_mode = 1; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            gnt_pct = $urandom_range(30, 100);
            inst_ready = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 3);
            redirect_pc = $urandom();
            step();
        end
        redirect_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetch_stall !== 32'(m_stall) || perf_flush_drop !== 32'(m_drop)) begin
            errors++;
            $display("FAIL random_perf: stall=%0d drop=%0d required %0d %0d",
                     perf_fetch_stall, perf_flush_drop, m_stall, m_drop);
        end
`endif
    endtask

    task automatic test_mid_reset();
        gnt_mode = 1; gnt_pct = 80; lat_min = 1; lat_max = 3;
        inst_ready = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        @(negedge clk);
        #1;
        check_reset_values("mid_reset");
        rst = 1'b0;
        clear_model();
        gnt_mode = 0; lat_min = 1; lat_max = 1;
        expect_first_pop("after_reset", RESET_PC);
        repeat (4) step();
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        int n = 0;
        apply_reset();
        gnt_mode = 0; lat_min = 1; lat_max = 1;
        inst_ready = 1'b0;
        while (!(occ == 3 && outs == 1) && n < 20) begin
            step();
            n++;
        end
        redirect_to(32'h40);
        gnt_mode = 2;
        repeat (3) step();
        checks++;
        if (perf_flush_drop !== 32'd4) begin
            errors++;
            $display("FAIL perf_flush_drop: got %0d required 4", perf_flush_drop);
        end
        inst_ready = 1'b1;
        repeat (5) step();
        checks++;
        if (perf_fetch_stall !== 32'd5) begin
            errors++;
            $display("FAIL perf_fetch_stall: got %0d required 5", perf_fetch_stall);
        end
    endtask
`endif

    initial begin
        clear_model();
        gnt_mode = 0; gnt_pct = 100; lat_min = 1; lat_max = 1;
        test_reset();
        test_stream();
        test_stall();
        test_gnt_wait();
        test_redirect();
        test_redirect_rvalid();
        test_back_to_back();
        test_random();
        test_mid_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
